receiver_compensation_calibrator: RTL and testbench
===================================================

Name: receiver_compensation_calibrator

Overview:
- Calibration sequencer for the receiver compensation stage.
- On `start`, it taps the same AXI-Stream that feeds the compensation block and averages 2^AVG_LOG2 complete frames per bin.
- It then writes the averaged per-bin baseline into the compensation block's coefficient memory, one AHB single write per bin.
- It sits beside the compensation block as an AHB master on its control slave port.

Parameters:
- DW, 16, sample and coefficient width (signed).
- DATA_CNT, 1024, bins per frame; must be a power of two, at most 1024.
- AVG_LOG2, 3, log2 of the number of frames averaged.
- BASE_ADDR, 32'h0000_0000, AHB address of coefficient 0.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a calibration run
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at the end of a run (success or error)
- error  out  1  sticky AHB error flag; cleared on an accepted start
- frame_err  out  1  sticky malformed-frame flag; cleared on an accepted start
- tdata_s  in  DW  monitored sample
- tvalid_s  in  1  monitored valid
- tlast_s  in  1  monitored last beat of frame
- tuser_s  in  1  monitored frame-start marker
- tready_s  out  1  constant 1 (passive tap)
- haddr_m  out  32  AHB address
- htrans_m  out  2  AHB transfer type (IDLE / NONSEQ only)
- hwrite_m  out  1  AHB write enable
- hsize_m  out  3  constant 3'b001 (halfword)
- hburst_m  out  3  constant 3'b000 (SINGLE)
- hwdata_m  out  32  AHB write data
- hready_m  in  1  AHB ready
- hresp_m  in  1  AHB error response

Behaviour:

Reset values:
- busy, done, error, frame_err = 0.
- htrans_m = IDLE, hwrite_m = 0, haddr_m = 0, hwdata_m = 0.
- FSM in IDLE.

Start handling:
- `start` is accepted only in IDLE; it is ignored otherwise.

States and transitions:
- IDLE: on start, go to SYNC; clear error and frame_err; reset frame counter fcnt and bin index idx.
- SYNC: wait for a beat with tvalid_s && tuser_s. That beat is bin 0 of the frame and is processed as in ACCUM; then enter ACCUM.
- ACCUM: on each tvalid_s beat, perform acc[idx] = (fcnt==0 ? sext(tdata_s) : acc[idx] + sext(tdata_s)).
  - Accumulator width is DW+AVG_LOG2, signed; overflow is impossible by construction.
  - idx increments per beat.
  - When tlast_s is high with idx == DATA_CNT-1:
    - increment fcnt and set idx = 0;
    - if fcnt reaches 2^AVG_LOG2, go to WADDR with widx = 0;
    - otherwise stay in ACCUM (the next frame must follow directly).
- Malformed frame: tlast_s at idx != DATA_CNT-1, or a beat at idx == DATA_CNT-1 without tlast_s.
  - Set frame_err, reset fcnt = 0, return to SYNC. Partial sums are discarded.
  - A tuser_s beat seen in ACCUM with idx != 0 is also malformed.
- WADDR: address phase.
  - Drive htrans_m = NONSEQ, hwrite_m = 1, haddr_m = BASE_ADDR + 2*widx.
  - Start the accumulator RAM read of acc[widx] (1-cycle read latency).
  - Advance to WDATA when hready_m = 1.
- WDATA: data phase.
  - Drive htrans_m = IDLE and hwdata_m = {16'h0000, acc[widx] >>> AVG_LOG2} (arithmetic shift, low DW bits), sign-extended to 16 if DW < 16.
  - Hold while hready_m = 0.
  - On hready_m = 1 with hresp_m = 1: set error, go to FIN.
  - On hready_m = 1 with hresp_m = 0: if widx == DATA_CNT-1 go to FIN, else widx++ and go to WADDR.
- FIN: pulse done for one cycle, drop busy, go to IDLE.

Latency and throughput:
- The minimum write phase is 2*DATA_CNT cycles.
- A full run is at least 2^AVG_LOG2 frames plus the write phase.

Handshake and reset rules:
- The stream is never back-pressured.
- Beats with tvalid_s = 0 are ignored in every state.
- Reset mid-run aborts immediately; no partial AHB transfer is completed.
- Accumulator RAM contents are undefined after reset but are always written in frame 0 before being read.

Decomposition:
- Package receiver_compensation_pkg holds:
  - HTRANS_IDLE = 2'b00, HTRANS_NONSEQ = 2'b10, HSIZE_HALF = 3'b001, HBURST_SINGLE = 3'b000;
  - FSM state encoding (IDLE, SYNC, ACCUM, WADDR, WDATA, FIN).
- Sub-module calib_acc_ram: simple dual-port RAM, DATA_CNT x (DW+AVG_LOG2).
  - One write port and one registered read port with 1-cycle latency.
  - The read-modify-write in ACCUM uses the read port one beat ahead, with write-to-read bypass on an address match.

Test Plan:
1. DW=16, AVG_LOG2=3, DATA_CNT=16; stream 8 frames with bin k = 100*k -> 16 writes, haddr = BASE+2k, hwdata[15:0] = 100*k, done pulse, error = 0.
2. Frames alternating bin value +5 and -3 over 8 frames -> every coefficient = 1 (sum 8, >>>3); all-negative input -32768 -> coefficient 16'h8000.
3. tlast_s at idx = 9 in frame 3 -> frame_err = 1, resync on the next tuser_s; the run completes after 8 further clean frames with correct averages.
4. hready_m held low 3 cycles in each data phase -> hwdata_m and haddr_m stable; 16 writes complete, with no lost or duplicated write.
5. hresp_m = 1 on the write at widx = 5 -> error = 1, done pulse, no further NONSEQ; the next start clears error.
6. Assert reset_n low during WDATA -> htrans_m = IDLE and busy = 0 asynchronously; start after reset runs cleanly; start pulsed while busy is ignored.

Source files
------------

// File: rtl/receiver_compensation_pkg.sv
// AHB encodings and FSM state type shared by the receiver compensation calibrator.
package receiver_compensation_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {IDLE, SYNC, ACCUM, WADDR, WDATA, FIN} state_t;

endpackage

// File: rtl/calib_acc_ram.sv
// Per-bin accumulator storage: one write port, one registered read port with
// write-to-read bypass so a same-cycle write to the read address is seen.
module calib_acc_ram #(
  parameter int DEPTH  = 1024,
  parameter int WIDTH  = 19,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/receiver_compensation_calibrator.sv
// Averages 2^AVG_LOG2 monitored frames per bin, then writes the per-bin baseline
// into the compensation coefficient memory with one AHB single write per bin.
module receiver_compensation_calibrator
  import receiver_compensation_pkg::*;
#(
  parameter int          DW        = 16,
  parameter int          DATA_CNT  = 1024,
  parameter int          AVG_LOG2  = 3,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          frame_err,
  input  logic [DW-1:0] tdata_s,
  input  logic          tvalid_s,
  input  logic          tlast_s,
  input  logic          tuser_s,
  output logic          tready_s,
  output logic [31:0]   haddr_m,
  output logic [1:0]    htrans_m,
  output logic          hwrite_m,
  output logic [2:0]    hsize_m,
  output logic [2:0]    hburst_m,
  output logic [31:0]   hwdata_m,
  input  logic          hready_m,
  input  logic          hresp_m
);

  localparam int AW = DW + AVG_LOG2;
  localparam int IW = $clog2(DATA_CNT);
  localparam int FW = AVG_LOG2 + 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(DATA_CNT - 1);
  localparam logic [FW-1:0] LAST_FRAME = FW'((1 << AVG_LOG2) - 1);

  state_t               state;
  logic [IW-1:0]        idx, idx_next, widx, widx_inc, raddr;
  logic [FW-1:0]        fcnt;
  logic                 beat, at_last, malformed, ram_we;
  logic [AW-1:0]        sample_ext, ram_wdata, rd_data;
  logic signed [DW-1:0] sample, coef_dw;

  assign tready_s = 1'b1;
  assign hsize_m  = HSIZE_HALF;
  assign hburst_m = HBURST_SINGLE;

  assign sample     = tdata_s;
  assign sample_ext = AW'(sample);

  assign beat      = tvalid_s && (state == ACCUM || (state == SYNC && tuser_s));
  assign at_last   = (idx == LAST_IDX);
  assign malformed = (tlast_s != at_last) || (tuser_s && idx != '0);
  assign ram_we    = beat && !malformed;
  assign ram_wdata = (fcnt == '0) ? sample_ext : rd_data + sample_ext;
  assign widx_inc  = widx + 1'b1;

  always_comb begin
    idx_next = idx;
    if (beat) idx_next = (malformed || at_last) ? '0 : idx + 1'b1;
  end

  // Accumulation pre-reads the bin the next beat will hit; write phase reads widx.
  assign raddr = (state == WADDR || state == WDATA) ? widx : idx_next;

  calib_acc_ram #(.DEPTH(DATA_CNT), .WIDTH(AW), .ADDR_W(IW)) u_acc_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (idx),
    .wdata (ram_wdata),
    .raddr (raddr),
    .rdata (rd_data)
  );

  // Upper DW bits of the sum are the arithmetic shift by AVG_LOG2.
  assign coef_dw  = rd_data[AW-1:AVG_LOG2];
  assign hwdata_m = (state == WDATA) ? {16'h0000, 16'(coef_dw)} : 32'h0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      widx      <= '0;
      fcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      frame_err <= 1'b0;
      htrans_m  <= HTRANS_IDLE;
      hwrite_m  <= 1'b0;
      haddr_m   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state     <= SYNC;
          busy      <= 1'b1;
          error     <= 1'b0;
          frame_err <= 1'b0;
          fcnt      <= '0;
          idx       <= '0;
        end
        SYNC, ACCUM: if (beat) begin
          idx <= idx_next;
          if (malformed) begin
            frame_err <= 1'b1;
            fcnt      <= '0;
            state     <= SYNC;
          end else if (at_last && fcnt == LAST_FRAME) begin
            fcnt     <= fcnt + 1'b1;
            state    <= WADDR;
            widx     <= '0;
            htrans_m <= HTRANS_NONSEQ;
            hwrite_m <= 1'b1;
            haddr_m  <= BASE_ADDR;
          end else begin
            if (at_last) fcnt <= fcnt + 1'b1;
            state <= ACCUM;
          end
        end
        WADDR: if (hready_m) begin
          state    <= WDATA;
          htrans_m <= HTRANS_IDLE;
          hwrite_m <= 1'b0;
        end
        WDATA: if (hready_m) begin
          if (hresp_m || widx == LAST_IDX) begin
            error <= error | hresp_m;
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            widx     <= widx_inc;
            state    <= WADDR;
            htrans_m <= HTRANS_NONSEQ;
            hwrite_m <= 1'b1;
            haddr_m  <= BASE_ADDR + (32'(widx_inc) << 1);
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_receiver_compensation_calibrator.sv
// Randomized bench: frame-averaging reference model plus a behavioural AHB slave.
module tb_receiver_compensation_calibrator;

  localparam int          DW       = 16;
  localparam int          DATA_CNT = 16;
  localparam int          AVG_LOG2 = 3;
  localparam int          NFR      = 1 << AVG_LOG2;
  localparam logic [31:0] BASE     = 32'h0000_4000;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic          busy, done, error, frame_err, tready_s;
  logic [DW-1:0] tdata_s = '0;
  logic          tvalid_s = 1'b0, tlast_s = 1'b0, tuser_s = 1'b0;
  logic [31:0]   haddr_m, hwdata_m;
  logic [1:0]    htrans_m;
  logic          hwrite_m;
  logic [2:0]    hsize_m, hburst_m;
  logic          hready_m = 1'b1, hresp_m = 1'b0;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  receiver_compensation_calibrator #(
    .DW(DW), .DATA_CNT(DATA_CNT), .AVG_LOG2(AVG_LOG2), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .error(error), .frame_err(frame_err), .tdata_s(tdata_s), .tvalid_s(tvalid_s),
    .tlast_s(tlast_s), .tuser_s(tuser_s), .tready_s(tready_s), .haddr_m(haddr_m),
    .htrans_m(htrans_m), .hwrite_m(hwrite_m), .hsize_m(hsize_m), .hburst_m(hburst_m),
    .hwdata_m(hwdata_m), .hready_m(hready_m), .hresp_m(hresp_m)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // AHB slave: optional wait states per data phase, optional error on one write.
  int          stall_cycles = 0, err_idx = -1, nonseq_cnt = 0;
  int          wait_left = 0, data_cycle = 0;
  bit          in_data = 1'b0;
  logic [31:0] cur_addr, held_data;
  logic [31:0] wr_addr[$], wr_data[$];

  always @(negedge clk) begin
    if (!reset_n) begin
      in_data  = 1'b0;
      hready_m = 1'b1;
      hresp_m  = 1'b0;
    end else if (in_data) begin
      if (data_cycle == 0) held_data = hwdata_m;
      else begin
        check_val("hold_wdata", hwdata_m, held_data);
        check_val("hold_addr", haddr_m, cur_addr);
      end
      data_cycle++;
      if (wait_left > 0) begin
        hready_m = 1'b0;
        wait_left--;
      end else begin
        hready_m = 1'b1;
        hresp_m  = (wr_addr.size() == err_idx);
        wr_addr.push_back(cur_addr);
        wr_data.push_back(hwdata_m);
        $display("AHB write addr=%h data=%h resp=%0d", cur_addr, hwdata_m, hresp_m);
        in_data = 1'b0;
      end
    end else begin
      hready_m = 1'b1;
      hresp_m  = 1'b0;
      if (htrans_m == 2'b10) begin
        cur_addr = haddr_m;
        nonseq_cnt++;
        check_val("hwrite_addr_phase", {31'h0, hwrite_m}, 32'h1);
        in_data    = 1'b1;
        wait_left  = stall_cycles;
        data_cycle = 0;
      end
    end
  end

  // Reference model: per-bin sums of the last run of NFR clean frames.
  int fv[DATA_CNT];
  int msum[DATA_CNT];
  int mframes = 0;

  function automatic logic [31:0] exp_coef(input int k);
    int s = msum[k];
    int q = (s >= 0) ? s / NFR : -((-s + NFR - 1) / NFR);
    return {16'h0000, 16'(q)};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < DATA_CNT; k++) msum[k] = 0;
    mframes = 0;
  endtask

  task automatic idle_gap();
    int n = $urandom_range(0, 2);
    repeat (n) begin
      @(negedge clk);
      tvalid_s = 1'b0;
      tdata_s  = DW'($urandom);
      tuser_s  = 1'($urandom);
      tlast_s  = 1'($urandom);
    end
  endtask

  task automatic send_frame(input int cut_at);
    for (int i = 0; i < DATA_CNT; i++) begin
      idle_gap();
      @(negedge clk);
      tvalid_s = 1'b1;
      tdata_s  = DW'(fv[i]);
      tuser_s  = (i == 0);
      tlast_s  = (i == DATA_CNT - 1) || (i == cut_at);
      if (i == cut_at) break;
    end
    @(negedge clk);
    tvalid_s = 1'b0; tuser_s = 1'b0; tlast_s = 1'b0;
    if (cut_at >= 0) model_clear();
    else if (mframes < NFR) begin
      for (int k = 0; k < DATA_CNT; k++) msum[k] += fv[k];
      mframes++;
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < DATA_CNT; k++) fv[k] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic fill_const(input int v);
    for (int k = 0; k < DATA_CNT; k++) fv[k] = v;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic begin_run(input string tag);
    wr_addr.delete(); wr_data.delete();
    nonseq_cnt = 0;
    model_clear();
    pulse_start();
    check_val({tag, "_busy"}, {31'h0, busy}, 32'h1);
    check_val({tag, "_err_clr"}, {31'h0, error}, 32'h0);
    check_val({tag, "_ferr_clr"}, {31'h0, frame_err}, 32'h0);
  endtask

  task automatic finish_run(input string tag, input int n_exp, input bit exp_err, input bit exp_ferr);
    int cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_val({tag, "_done"}, {31'h0, done}, 32'h1);
    check_val({tag, "_busy_low"}, {31'h0, busy}, 32'h0);
    check_val({tag, "_error"}, {31'h0, error}, {31'h0, exp_err});
    check_val({tag, "_frame_err"}, {31'h0, frame_err}, {31'h0, exp_ferr});
    @(negedge clk);
    check_val({tag, "_done_pulse"}, {31'h0, done}, 32'h0);
    repeat (4) @(negedge clk);
    check_val({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(n_exp));
    check_val({tag, "_nonseq"}, 32'(nonseq_cnt), 32'(n_exp));
    for (int i = 0; i < wr_addr.size() && i < DATA_CNT; i++) begin
      check_val($sformatf("%s_addr%0d", tag, i), wr_addr[i], BASE + 32'(2 * i));
      check_val($sformatf("%s_data%0d", tag, i), wr_data[i], exp_coef(i));
    end
    $display("run %s: %0d writes, error=%0d frame_err=%0d", tag, wr_addr.size(), error, frame_err);
  endtask

  task automatic random_frames(input int n);
    repeat (n) begin
      fill_random();
      send_frame(-1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    check_val("rst_busy", {31'h0, busy}, 32'h0);
    check_val("rst_done", {31'h0, done}, 32'h0);
    check_val("rst_error", {31'h0, error}, 32'h0);
    check_val("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check_val("rst_htrans", {30'h0, htrans_m}, 32'h0);
    check_val("rst_hwrite", {31'h0, hwrite_m}, 32'h0);
    check_val("rst_haddr", haddr_m, 32'h0);
    check_val("rst_hwdata", hwdata_m, 32'h0);
    check_val("tready", {31'h0, tready_s}, 32'h1);
    check_val("hsize", {29'h0, hsize_m}, 32'h1);
    check_val("hburst", {29'h0, hburst_m}, 32'h0);
    reset_n = 1'b1;

    // Ramp: bin k = 100*k, preceded by valid non-marker beats that SYNC ignores.
    begin_run("ramp");
    repeat (3) begin
      @(negedge clk);
      tvalid_s = 1'b1; tuser_s = 1'b0; tlast_s = 1'($urandom); tdata_s = DW'($urandom);
    end
    @(negedge clk); tvalid_s = 1'b0; tlast_s = 1'b0;
    for (int k = 0; k < DATA_CNT; k++) fv[k] = 100 * k;
    repeat (NFR) send_frame(-1);
    finish_run("ramp", DATA_CNT, 1'b0, 1'b0);

    begin_run("alt");
    for (int f = 0; f < NFR; f++) begin
      fill_const((f % 2 == 0) ? 5 : -3);
      send_frame(-1);
    end
    finish_run("alt", DATA_CNT, 1'b0, 1'b0);

    begin_run("minneg");
    fill_const(-32768);
    repeat (NFR) send_frame(-1);
    finish_run("minneg", DATA_CNT, 1'b0, 1'b0);

    for (int r = 0; r < 2; r++) begin
      begin_run($sformatf("rand%0d", r));
      random_frames(NFR);
      finish_run($sformatf("rand%0d", r), DATA_CNT, 1'b0, 1'b0);
    end

    // Early tlast in frame 3 discards the partial average and forces a resync.
    begin_run("badframe");
    random_frames(3);
    fill_random();
    send_frame(9);
    check_val("badframe_flag", {31'h0, frame_err}, 32'h1);
    random_frames(NFR);
    finish_run("badframe", DATA_CNT, 1'b0, 1'b1);

    stall_cycles = 3;
    begin_run("stall");
    random_frames(NFR);
    finish_run("stall", DATA_CNT, 1'b0, 1'b0);
    stall_cycles = 0;

    err_idx = 5;
    begin_run("hresp");
    random_frames(NFR);
    finish_run("hresp", 6, 1'b1, 1'b0);
    err_idx = -1;

    begin_run("after_err");
    random_frames(NFR);
    finish_run("after_err", DATA_CNT, 1'b0, 1'b0);

    // Reset during a data phase, then a clean run with an ignored mid-run start.
    begin_run("abort");
    random_frames(NFR);
    cyc = 0;
    while (!(in_data && wr_addr.size() >= 3) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_val("abort_reach_wdata", {31'h0, in_data}, 32'h1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check_val("abort_htrans", {30'h0, htrans_m}, 32'h0);
    check_val("abort_busy", {31'h0, busy}, 32'h0);
    check_val("abort_hwdata", hwdata_m, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    begin_run("post_reset");
    random_frames(NFR / 2);
    pulse_start();
    check_val("ignored_start_busy", {31'h0, busy}, 32'h1);
    random_frames(NFR / 2);
    finish_run("post_reset", DATA_CNT, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
